uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte-serialising UART transmitter with a small input FIFO. It is the far end of the tx_data/tx_start/tx_busy interface that the mode blocks (setting, input, display) drive. It accepts bytes on single-cycle tx_start strobes and emits 8N1 frames, LSB first, on uart_txd. Queued bytes are sent back-to-back with no idle gap, so mode blocks can emit short replies without waiting per byte.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division, must be >= 2). Each bit lasts exactly BAUD_DIV clocks.
- FIFO_DEPTH, 16: byte capacity of the FIFO. Power of two, >= 2.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- tx_data, input, 8: byte to enqueue; sampled only when tx_start is high.
- tx_start, input, 1: single-cycle enqueue strobe.
- tx_busy, output, 1: high while the FIFO is full; writers must not strobe while it is high.
- tx_idle, output, 1: high when the FIFO is empty and no frame is in progress.
- overflow, output, 1: one-cycle pulse when tx_start arrives while full.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: number of queued bytes, excluding the byte currently on the line.
- uart_txd, output, 1: serial line; idles high.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - uart_txd=1, tx_busy=0, tx_idle=1, overflow=0, fifo_count=0.
  - FSM goes to IDLE; read/write pointers, baud counter and bit counter are cleared.
  - Any queued bytes and any partial frame are discarded.
- Enqueue:
  - At an edge where tx_start=1 and the pre-edge fifo_count < FIFO_DEPTH, tx_data is written at the write pointer and the pointer advances (wraps modulo FIFO_DEPTH).
  - If the pre-edge count == FIFO_DEPTH, the byte is dropped and overflow is high for the following cycle only. FIFO state is unchanged.
  - The full check uses the pre-edge count. A pop in the same cycle does not rescue a push made while full.
- Dequeue: the FSM pops at the edge where it leaves IDLE or STOP with the FIFO non-empty.
- Simultaneous push and pop: allowed when not full; fifo_count is unchanged.
- No bypass: a byte written into an empty FIFO is popped at the next edge at the earliest.
- tx_busy is a registered copy of (count == FIFO_DEPTH) after the edge's update.
- tx_idle = (state == IDLE) && (count == 0), decoded from registers.
- FSM states: IDLE, START, DATA, STOP. uart_txd is registered and changes at the same edge as the state/bit change.
  - IDLE: uart_txd=1. If count != 0: pop into the shift register, set baud_cnt=0, go to START.
  - START: uart_txd=0. After BAUD_DIV clocks, go to DATA with bit index 0.
  - DATA: uart_txd = shift[bit]. Every BAUD_DIV clocks, increment bit. After bit 7 completes, go to STOP.
  - STOP: uart_txd=1 for BAUD_DIV clocks. Then:
    - if count != 0: pop and go directly to START (no idle cycles between frames);
    - otherwise go to IDLE.
- Frame length is exactly 10*BAUD_DIV clocks.
- Latency: with tx_start sampled at edge N into an empty FIFO in IDLE, the FSM pops at edge N+1 and uart_txd falls at edge N+1.
- baud_cnt counts 0..BAUD_DIV-1 and wraps to 0 on each bit boundary. Its width is $clog2(BAUD_DIV).
- tx_data is ignored when tx_start=0. The FIFO storage needs no reset, but pointers and count must be reset.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, BAUD_RATE=250_000 (BAUD_DIV=4) and FIFO_DEPTH=4.
1. Reset: assert rst_n=0 for 3 cycles → uart_txd=1, tx_busy=0, tx_idle=1, overflow=0, fifo_count=0 throughout and after release.
2. Single byte: strobe tx_data=0x53 ('S') at edge N →
   - uart_txd=0 during edges N+1..N+4;
   - data bits 1,1,0,0,1,0,1,0 for 4 cycles each;
   - stop bit 1 from N+37 to N+40;
   - tx_idle returns to 1 at N+41.
3. Back-to-back: strobe 0x41, 0x42, 0x43 on three consecutive edges → three contiguous 40-cycle frames totalling 120 cycles. Each stop bit is followed immediately by the next start bit; the decoded bytes are 0x41, 0x42, 0x43.
4. Overflow: strobe 6 bytes on consecutive edges N..N+5 →
   - fifo_count reads 1,1,2,3,4 after N..N+4;
   - tx_busy=1 after N+4;
   - the byte at N+5 is dropped and overflow is high for exactly one cycle;
   - exactly 5 frames are transmitted, in order.
5. Reset mid-frame: drop rst_n during DATA bit 3 of a frame while 2 bytes are queued → uart_txd=1 immediately (asynchronous), fifo_count=0. After release, no further frames are sent.
6. Handshake: a writer strobes only when !tx_busy while 10 bytes are pushed into the depth-4 FIFO → overflow is never asserted and all 10 bytes are received in order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; queued bytes go out back-to-back.
// Writers strobe tx_start with a byte; tx_busy tells them the FIFO is full.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_start,
    output logic                          tx_busy,
    output logic                          tx_idle,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          uart_txd
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic          full;
    logic          empty;
    logic          baud_done;
    logic          push;
    logic          pop;
    logic [AW:0]   count_next;

    assign full      = (fifo_count == FULL);
    assign empty     = (fifo_count == '0);
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign push      = tx_start && !full;
    // Pop only from registered state, so a byte written this cycle is never bypassed.
    assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_done));
    assign tx_idle   = (state == IDLE) && empty;

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - (AW + 1)'(1);
        end
    end

    // NOTE: storage has no reset; contents are only read behind a reset-cleared count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            uart_txd   <= 1'b1;
            tx_busy    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            fifo_count <= count_next;
            tx_busy    <= (count_next == FULL);
            overflow   <= tx_start && full;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                shift  <= mem[rd_ptr];
            end

            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (pop) begin
                        state    <= START;
                        baud_cnt <= '0;
                        uart_txd <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        uart_txd <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // A queued byte starts its frame immediately after the stop bit.
                        if (pop) begin
                            state    <= START;
                            uart_txd <= 1'b0;
                        end else begin
                            state    <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line monitor decodes frames and checks them
// against a queue of bytes the stimulus expects to see, in order.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int BAUD_RATE  = 250_000;
    localparam int FIFO_DEPTH = 4;
    localparam int BAUD_DIV   = CLK_FREQ / BAUD_RATE;
    localparam int FRAME      = 10 * BAUD_DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_idle;
    logic       overflow;
    logic [2:0] fifo_count;
    logic       uart_txd;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int frames_rx   = 0;
    int frames_started = 0;
    int ovf_cnt     = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_idle   (tx_idle),
        .overflow  (overflow),
        .fifo_count(fifo_count),
        .uart_txd  (uart_txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Line monitor: sample each bit near its middle, abort the frame if reset hits.
    logic [7:0] rx_byte;
    logic       rx_abort;
    always begin
        @(negedge clk);
        if (rst_n === 1'b1 && uart_txd === 1'b0) begin
            starts.push_back(cyc);
            frames_started++;
            rx_abort = 1'b0;
            rx_byte  = '0;
            for (int k = 1; k < FRAME; k++) begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    rx_abort = 1'b1;
                    break;
                end
                if (k == 2) check("start_bit", uart_txd, 1'b0);
                else if (k == 9 * BAUD_DIV + 2) check("stop_bit", uart_txd, 1'b1);
                else if (k % BAUD_DIV == 2 && k < 9 * BAUD_DIV) rx_byte[k / BAUD_DIV - 1] = uart_txd;
            end
            if (!rx_abort) begin
                check("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("rx_byte", rx_byte, exp_q.pop_front());
                frames_rx++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txd"},   uart_txd,   1'b1);
        check({tag, "_busy"},  tx_busy,    1'b0);
        check({tag, "_idle"},  tx_idle,    1'b1);
        check({tag, "_ovf"},   overflow,   1'b0);
        check({tag, "_count"}, fifo_count, 3'd0);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && tx_idle === 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < 1000, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] ob [6];
    logic [2:0] exp_cnt [5];
    int fr0, ovf0, fs0, w;

    initial begin
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_data  = '0;

        // 1. Reset held for three cycles, then released.
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");
        @(negedge clk);

        // 2. Single byte: exact line timing relative to the sampling edge N.
        tx_start = 1'b1;
        tx_data  = 8'h53;
        exp_q.push_back(8'h53);
        @(negedge clk);
        tx_start = 1'b0;
        check("s_count_after_n", fifo_count, 3'd1);
        check("s_txd_after_n",   uart_txd,   1'b1);
        check("s_idle_after_n",  tx_idle,    1'b0);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k <= BAUD_DIV)          check("s_start", uart_txd, 1'b0);
            else if (k <= 9 * BAUD_DIV) check("s_data", uart_txd, 8'h53 >> ((k - BAUD_DIV - 1) / BAUD_DIV) & 1);
            else                        check("s_stop", uart_txd, 1'b1);
        end
        @(negedge clk);
        check("s_idle_n41", tx_idle, 1'b1);
        check("s_drained", exp_q.size(), 0);

        // 3. Back-to-back: three strobes on consecutive edges -> contiguous frames.
        starts.delete();
        tx_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data = 8'h41 + 8'(i);
            exp_q.push_back(tx_data);
            @(negedge clk);
        end
        tx_start = 1'b0;
        wait_drain("b2b_drain");
        check("b2b_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("b2b_gap1",  starts[1] - starts[0], FRAME);
            check("b2b_gap2",  starts[2] - starts[1], FRAME);
            check("b2b_total", starts[2] - starts[0] + FRAME, 3 * FRAME);
        end

        // 4. Overflow: six strobes into a depth-4 FIFO, the last one is dropped.
        ob      = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        fr0  = frames_rx;
        ovf0 = ovf_cnt;
        tx_start = 1'b1;
        tx_data  = ob[0];
        exp_q.push_back(ob[0]);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 5) check("ovf_count", fifo_count, exp_cnt[i]);
            check("ovf_busy", tx_busy, i >= 4);
            check("ovf_pulse", overflow, i == 5);
            if (i < 5) begin
                tx_data = ob[i + 1];
                if (i + 1 < 5) exp_q.push_back(ob[i + 1]);
            end else begin
                tx_start = 1'b0;
            end
        end
        @(negedge clk);
        check("ovf_pulse_end", overflow, 1'b0);
        wait_drain("ovf_drain");
        check("ovf_frames", frames_rx - fr0, 5);
        check("ovf_pulses", ovf_cnt - ovf0, 1);

        // 5. Reset during data bit 3 with two bytes still queued.
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h37;
        exp_q.push_back(8'h37);
        @(negedge clk);
        tx_data = 8'h5A;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        tx_data = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (16) @(negedge clk);
        check("mid_bit3", uart_txd, 1'b0);
        check("mid_count", fifo_count, 3'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fs0 = frames_started;
        repeat (100) @(negedge clk);
        check("mid_no_frames", frames_started - fs0, 0);
        check("mid_txd_high", uart_txd, 1'b1);
        check("mid_idle", tx_idle, 1'b1);

        // 6. Handshake: writer honours tx_busy while pushing ten bytes.
        fr0  = frames_rx;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 10; i++) begin
            w = 0;
            while (tx_busy !== 1'b0 && w < 500) begin
                tx_start = 1'b0;
                @(negedge clk);
                w++;
            end
            check("hs_wait", w < 500, 1);
            tx_start = 1'b1;
            tx_data  = 8'hC0 + 8'(i * 7);
            exp_q.push_back(tx_data);
            @(negedge clk);
            tx_start = 1'b0;
        end
        wait_drain("hs_drain");
        check("hs_frames", frames_rx - fr0, 10);
        check("hs_no_ovf", ovf_cnt - ovf0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
